wb_stage_ctrl: RTL and testbench
================================

WB_STAGE_CTRL -- requirements
Module: wb_stage_ctrl

Interface
REQ-001 SHALL have parameter W_SIZE, default 32, instruction/data width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of every performance counter.
REQ-003 SHALL have parameter TOHOST_ADDR, default 12'h51e, CSR address captured by tohost.
REQ-004 Ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Ports: rst  in  1  synchronous, active-high reset.
REQ-006 Ports: stall  in  1  holds W register and retire-side counters.
REQ-007 Ports: inst_x  in  W_SIZE  instruction leaving X stage; valid_x  in  1  0 = bubble.
REQ-008 Ports: br_taken_x  in  1  branch outcome from X; csr_src_x  in  W_SIZE  rs1 value for csrrw.
REQ-009 Ports: counter_rst  in  1  single-cycle counter clear strobe (MMIO write).
REQ-010 Ports: inst_w  out  W_SIZE; valid_w  out  1  registered W-stage instruction/valid.
REQ-011 Ports: pc_sel  out  2  0 PC+4, 1 ALU, 2 JAL-special, 3 BIOS reset; flush  out  1.
REQ-012 Ports: reg_wen  out  1; wb_sel  out  2  0 PC+4, 1 ALU, 2 MEM.
REQ-013 Ports: tohost  out  W_SIZE; cycle_cnt, instret_cnt  out  CNT_WIDTH.
REQ-014 Ports: br_cnt, br_taken_cnt  out  CNT_WIDTH  branch statistics (see Configuration).

Function
REQ-015 W register (inst_w, valid_w, br_taken_w, csr_src_w) SHALL load from X inputs each cycle stall=0; hold when stall=1.
REQ-016 Latency: X inputs SHALL appear on W outputs exactly one cycle after capture.
REQ-017 reg_wen SHALL be 1 iff valid_w & rd!=0 & opcode in {OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR}; 0 for STORE, BRANCH, SYSTEM, bubble.
REQ-018 wb_sel SHALL be 2 for LOAD, 0 for JAL/JALR, 1 otherwise; combinational from W register.
REQ-019 pc_sel SHALL be 3 while rst=1; else 1 if valid_w & (JALR | (BRANCH & br_taken_w)); else 2 if valid_w & JAL; else 0.
REQ-020 flush SHALL equal 1 iff pc_sel==1 and rst=0.
REQ-021 cycle_cnt SHALL increment by 1 every cycle, including stall cycles.
REQ-022 instret_cnt SHALL increment by 1 in a cycle with valid_w=1 and stall=0.
REQ-023 All counters SHALL wrap modulo 2^CNT_WIDTH (all-ones +1 -> 0), no saturation.
REQ-024 counter_rst=1 SHALL set all counters to 0 next cycle; clear wins over same-cycle increment.
REQ-025 tohost SHALL load csr_src_w on valid_w & stall=0 & opcode SYSTEM & funct3=3'b001 & inst_w[31:20]==TOHOST_ADDR.
REQ-026 tohost SHALL load zero-extended inst_w[19:15] for same condition with funct3=3'b101 (csrrwi).
REQ-027 CSR writes to any other address SHALL leave tohost unchanged; CSR ops never assert reg_wen.

Reset
REQ-028 rst SHALL override stall, counter_rst and all updates.
REQ-029 On rst: inst_w=32'h00000013, valid_w=0, br_taken_w=0, csr_src_w=0, tohost=0, all counters=0.
REQ-030 Outputs after reset: reg_wen=0, wb_sel=1, flush=0; pc_sel=3 during rst, 0 first cycle after.
REQ-031 rst mid-stall SHALL discard held W instruction; no retirement counted for it.

Configuration
REQ-032 Macro WB_BR_COUNTERS_EN defined: br_cnt SHALL increment on retiring (valid_w & stall=0) BRANCH; br_taken_cnt additionally requires br_taken_w; both obey REQ-023/024/029.
REQ-033 Macro undefined: br_cnt and br_taken_cnt SHALL be constant 0, no counter flops synthesized; all else identical.

Verification
REQ-034 rst 3 cycles, release -> cycle_cnt=1 one edge later, instret_cnt=0, pc_sel 3->0, inst_w=32'h00000013.
REQ-035 Issue addi x1,x0,5 valid, then jal x1 -> next cycle reg_wen=1 wb_sel=1; following cycle wb_sel=0 pc_sel=2; instret_cnt=2.
REQ-036 Taken beq with stall=1 for 2 cycles -> pc_sel=1, flush=1 held 3 cycles; instret_cnt +1 once; cycle_cnt +3; br_taken_cnt +1 if macro defined.
REQ-037 csrrwi 0x51e, zimm=17 -> tohost=17; csrrw 0x51e with csr_src_x=32'hDEADBEEF -> tohost=32'hDEADBEEF; csrrw 0x340 -> unchanged.
REQ-038 CNT_WIDTH=4, run 16 cycles -> cycle_cnt wraps 15->0; counter_rst with retiring inst same cycle -> instret_cnt=0.
REQ-039 Build without WB_BR_COUNTERS_EN, retire 3 taken branches -> br_cnt=0, br_taken_cnt=0.

Source files
------------

// File: rtl/wb_stage_ctrl.sv
// Write-back stage controller: W pipeline register, writeback/PC-select decode,
// tohost CSR capture and performance counters. Branch statistics need WB_BR_COUNTERS_EN.
module wb_stage_ctrl #(
    parameter int          W_SIZE      = 32,
    parameter int          CNT_WIDTH   = 32,
    parameter logic [11:0] TOHOST_ADDR = 12'h51e
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [W_SIZE-1:0]    inst_x,
    input  logic                 valid_x,
    input  logic                 br_taken_x,
    input  logic [W_SIZE-1:0]    csr_src_x,
    input  logic                 counter_rst,
    output logic [W_SIZE-1:0]    inst_w,
    output logic                 valid_w,
    output logic [1:0]           pc_sel,
    output logic                 flush,
    output logic                 reg_wen,
    output logic [1:0]           wb_sel,
    output logic [W_SIZE-1:0]    tohost,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] br_taken_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRWI = 3'b101;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_ALU   = 2'd1;
    localparam logic [1:0] PC_JAL   = 2'd2;
    localparam logic [1:0] PC_BIOS  = 2'd3;

    localparam logic [1:0] WB_PC4 = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    localparam logic [W_SIZE-1:0]    NOP_INST = {{(W_SIZE-32){1'b0}}, 32'h00000013};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [W_SIZE-1:0]    inst_w_r;
    logic                 valid_w_r;
    logic                 br_taken_w_r;
    logic [W_SIZE-1:0]    csr_src_w_r;
    logic [W_SIZE-1:0]    tohost_r;
    logic [W_SIZE-1:0]    tohost_next_s;
    logic [CNT_WIDTH-1:0] cycle_cnt_r;
    logic [CNT_WIDTH-1:0] instret_cnt_r;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [4:0] rd_s;
    logic       retire_s;
    logic       wr_class_s;
    logic [1:0] wb_sel_s;
    logic [1:0] pc_sel_s;

    assign opcode_s = inst_w_r[6:0];
    assign rd_s     = inst_w_r[11:7];
    assign funct3_s = inst_w_r[14:12];
    assign retire_s = valid_w_r && !stall;

    // W-stage pipeline register: captures X each unstalled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_w_r     <= NOP_INST;
            valid_w_r    <= 1'b0;
            br_taken_w_r <= 1'b0;
            csr_src_w_r  <= {W_SIZE{1'b0}};
        end else if (!stall) begin
            inst_w_r     <= inst_x;
            valid_w_r    <= valid_x;
            br_taken_w_r <= br_taken_x;
            csr_src_w_r  <= csr_src_x;
        end else begin
            inst_w_r     <= inst_w_r;
            valid_w_r    <= valid_w_r;
            br_taken_w_r <= br_taken_w_r;
            csr_src_w_r  <= csr_src_w_r;
        end
    end

    // Opcode classification for register write enable and writeback source
    always_comb begin
        wr_class_s = 1'b0;
        wb_sel_s   = WB_ALU;
        case (opcode_s)
            OPC_LOAD: begin
                wr_class_s = 1'b1;
                wb_sel_s   = WB_MEM;
            end
            OPC_JAL, OPC_JALR: begin
                wr_class_s = 1'b1;
                wb_sel_s   = WB_PC4;
            end
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                wr_class_s = 1'b1;
                wb_sel_s   = WB_ALU;
            end
            default: begin
                wr_class_s = 1'b0;
                wb_sel_s   = WB_ALU;
            end
        endcase
    end

    assign reg_wen = valid_w_r && (rd_s != 5'd0) && wr_class_s;
    assign wb_sel  = wb_sel_s;

    // Next-PC select; reset steers fetch to the BIOS vector
    always_comb begin
        if (rst) begin
            pc_sel_s = PC_BIOS;
        end else if (valid_w_r && ((opcode_s == OPC_JALR) ||
                                   ((opcode_s == OPC_BRANCH) && br_taken_w_r))) begin
            pc_sel_s = PC_ALU;
        end else if (valid_w_r && (opcode_s == OPC_JAL)) begin
            pc_sel_s = PC_JAL;
        end else begin
            pc_sel_s = PC_PLUS4;
        end
    end

    assign pc_sel = pc_sel_s;
    assign flush  = (pc_sel_s == PC_ALU) && !rst;

    // tohost capture for csrrw/csrrwi retiring to the tohost address
    always_comb begin
        tohost_next_s = tohost_r;
        if (retire_s && (opcode_s == OPC_SYSTEM) && (inst_w_r[31:20] == TOHOST_ADDR)) begin
            case (funct3_s)
                F3_CSRRW:  tohost_next_s = csr_src_w_r;
                F3_CSRRWI: tohost_next_s = {{(W_SIZE-5){1'b0}}, inst_w_r[19:15]};
                default:   tohost_next_s = tohost_r;
            endcase
        end else begin
            tohost_next_s = tohost_r;
        end
    end

    // tohost register
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_r <= {W_SIZE{1'b0}};
        end else begin
            tohost_r <= tohost_next_s;
        end
    end

    // Cycle and retired-instruction counters; the clear strobe beats increments
    always_ff @(posedge clk) begin
        if (rst || counter_rst) begin
            cycle_cnt_r   <= CNT_ZERO;
            instret_cnt_r <= CNT_ZERO;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            if (retire_s) begin
                instret_cnt_r <= instret_cnt_r + CNT_ONE;
            end else begin
                instret_cnt_r <= instret_cnt_r;
            end
        end
    end

`ifdef WB_BR_COUNTERS_EN
    logic [CNT_WIDTH-1:0] br_cnt_r;
    logic [CNT_WIDTH-1:0] br_taken_cnt_r;
    logic                 br_retire_s;

    assign br_retire_s = retire_s && (opcode_s == OPC_BRANCH);

    // Branch statistics counters
    always_ff @(posedge clk) begin
        if (rst || counter_rst) begin
            br_cnt_r       <= CNT_ZERO;
            br_taken_cnt_r <= CNT_ZERO;
        end else begin
            if (br_retire_s) begin
                br_cnt_r <= br_cnt_r + CNT_ONE;
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (br_retire_s && br_taken_w_r) begin
                br_taken_cnt_r <= br_taken_cnt_r + CNT_ONE;
            end else begin
                br_taken_cnt_r <= br_taken_cnt_r;
            end
        end
    end

    assign br_cnt       = br_cnt_r;
    assign br_taken_cnt = br_taken_cnt_r;
`else
    assign br_cnt       = CNT_ZERO;
    assign br_taken_cnt = CNT_ZERO;
`endif

    assign inst_w      = inst_w_r;
    assign valid_w     = valid_w_r;
    assign tohost      = tohost_r;
    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Self-checking bench for wb_stage_ctrl: directed scenarios then randomized traffic,
// compared each cycle against a behavioural model of the W stage.
module tb_wb_stage_ctrl;

    localparam int          CW   = 4;
    localparam int unsigned CMOD = 32'd1 << CW;
`ifdef WB_BR_COUNTERS_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stall, valid_x, br_taken_x, counter_rst;
    logic [31:0]   inst_x, csr_src_x;
    logic [31:0]   inst_w, tohost;
    logic          valid_w, flush, reg_wen;
    logic [1:0]    pc_sel, wb_sel;
    logic [CW-1:0] cycle_cnt, instret_cnt, br_cnt, br_taken_cnt;

    wb_stage_ctrl #(.W_SIZE(32), .CNT_WIDTH(CW), .TOHOST_ADDR(12'h51e)) dut (
        .clk(clk), .rst(rst), .stall(stall), .inst_x(inst_x), .valid_x(valid_x),
        .br_taken_x(br_taken_x), .csr_src_x(csr_src_x), .counter_rst(counter_rst),
        .inst_w(inst_w), .valid_w(valid_w), .pc_sel(pc_sel), .flush(flush),
        .reg_wen(reg_wen), .wb_sel(wb_sel), .tohost(tohost), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt), .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: the instruction sitting in W plus architectural side effects
    logic [31:0] m_inst, m_csr, m_tohost;
    logic        m_valid, m_br;
    int unsigned m_cyc, m_ret, m_brc, m_brt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied
    task automatic model_edge();
        logic [6:0] op;
        logic [2:0] f3;
        bit         ret;
        op  = m_inst[6:0];
        f3  = m_inst[14:12];
        ret = m_valid && !stall;
        if (rst) begin
            m_inst = 32'h00000013; m_valid = 1'b0; m_br = 1'b0; m_csr = 32'd0;
            m_tohost = 32'd0; m_cyc = 0; m_ret = 0; m_brc = 0; m_brt = 0;
        end else begin
            if (ret && op == 7'h73 && m_inst[31:20] == 12'h51e) begin
                if (f3 == 3'd1) m_tohost = m_csr;
                else if (f3 == 3'd5) m_tohost = {27'd0, m_inst[19:15]};
            end
            if (counter_rst) begin
                m_cyc = 0; m_ret = 0; m_brc = 0; m_brt = 0;
            end else begin
                m_cyc = (m_cyc + 1) % CMOD;
                if (ret) m_ret = (m_ret + 1) % CMOD;
                if (BR_EN && ret && op == 7'h63) begin
                    m_brc = (m_brc + 1) % CMOD;
                    if (m_br) m_brt = (m_brt + 1) % CMOD;
                end
            end
            if (!stall) begin
                m_inst = inst_x; m_valid = valid_x; m_br = br_taken_x; m_csr = csr_src_x;
            end
        end
    endtask

    task automatic check_outputs();
        logic [6:0] op;
        bit         wr;
        int         e_wb, e_pc;
        op   = m_inst[6:0];
        wr   = m_valid && (m_inst[11:7] != 5'd0) &&
               (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6f, 7'h67});
        e_wb = (op == 7'h03) ? 2 : ((op == 7'h6f || op == 7'h67) ? 0 : 1);
        if (rst) e_pc = 3;
        else if (m_valid && (op == 7'h67 || (op == 7'h63 && m_br))) e_pc = 1;
        else if (m_valid && op == 7'h6f) e_pc = 2;
        else e_pc = 0;
        check_val("inst_w",       64'(inst_w),       64'(m_inst));
        check_val("valid_w",      64'(valid_w),      64'(m_valid));
        check_val("reg_wen",      64'(reg_wen),      64'(wr));
        check_val("wb_sel",       64'(wb_sel),       64'(e_wb));
        check_val("pc_sel",       64'(pc_sel),       64'(e_pc));
        check_val("flush",        64'(flush),        64'(e_pc == 1));
        check_val("tohost",       64'(tohost),       64'(m_tohost));
        check_val("cycle_cnt",    64'(cycle_cnt),    64'(m_cyc));
        check_val("instret_cnt",  64'(instret_cnt),  64'(m_ret));
        check_val("br_cnt",       64'(br_cnt),       64'(m_brc));
        check_val("br_taken_cnt", 64'(br_taken_cnt), 64'(m_brt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [0:9] = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17,
                                   7'h6f, 7'h67, 7'h63, 7'h23, 7'h73};
        logic [2:0]  f3s [0:3] = '{3'd1, 3'd5, 3'd2, 3'd0};
        logic [31:0] r;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [11:0] csr_a;
        r     = $urandom;
        rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : r[11:7];
        op    = ops[$urandom_range(0, 9)];
        csr_a = ($urandom_range(0, 3) != 0) ? 12'h51e : 12'h340;
        if (op == 7'h73) return {csr_a, r[19:15], f3s[$urandom_range(0, 3)], rd, op};
        return {r[31:12], rd, op};
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; valid_x = 1'b0; br_taken_x = 1'b0;
        counter_rst = 1'b0; inst_x = 32'h00000013; csr_src_x = 32'd0;
        repeat (3) step();
        check_val("rst_pc_sel", 64'(pc_sel), 64'd3);
        rst = 1'b0;
        step();
        check_val("rel_cycle", 64'(cycle_cnt), 64'd1);
        check_val("rel_instret", 64'(instret_cnt), 64'd0);
        check_val("rel_inst_w", 64'(inst_w), 64'h13);

        // addi x1,x0,5 followed by jal x1,8
        valid_x = 1'b1; inst_x = 32'h00500093; step();
        check_val("addi_reg_wen", 64'(reg_wen), 64'd1);
        inst_x = 32'h008000ef; step();
        check_val("jal_pc_sel", 64'(pc_sel), 64'd2);
        valid_x = 1'b0; step();
        check_val("jal_instret", 64'(instret_cnt), 64'd2);

        // tohost via csrrwi / csrrw / csrrw to another CSR
        valid_x = 1'b1; inst_x = {12'h51e, 5'd17, 3'b101, 5'd0, 7'h73}; step();
        valid_x = 1'b0; step();
        check_val("csrrwi_tohost", 64'(tohost), 64'd17);
        valid_x = 1'b1; csr_src_x = 32'hDEADBEEF;
        inst_x = {12'h51e, 5'd1, 3'b001, 5'd0, 7'h73}; step();
        valid_x = 1'b0; step();
        check_val("csrrw_tohost", 64'(tohost), 64'hDEADBEEF);
        valid_x = 1'b1; csr_src_x = 32'h12345678;
        inst_x = {12'h340, 5'd1, 3'b001, 5'd0, 7'h73}; step();
        valid_x = 1'b0; step();
        check_val("csrrw_other", 64'(tohost), 64'hDEADBEEF);

        // taken beq held by a two-cycle stall
        valid_x = 1'b1; br_taken_x = 1'b1; inst_x = 32'h00208063; step();
        valid_x = 1'b0; br_taken_x = 1'b0; stall = 1'b1; step(); step();
        stall = 1'b0; step();
        check_val("beq_flush_done", 64'(flush), 64'd0);

        // counter clear coinciding with a retiring instruction
        valid_x = 1'b1; inst_x = 32'h00500093; step();
        valid_x = 1'b0; counter_rst = 1'b1; step();
        check_val("clr_instret", 64'(instret_cnt), 64'd0);
        counter_rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            counter_rst = ($urandom_range(0, 24) == 0);
            valid_x     = ($urandom_range(0, 4) != 0);
            br_taken_x  = $urandom_range(0, 1) == 1;
            csr_src_x   = $urandom;
            inst_x      = rand_inst();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
